// File: rtl/niosii_pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The CPU side drives the master modport and the PIO owns the slave modport.
interface niosii_pio_in_edge_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/niosii_pio_in_edge_irq.sv
// Avalon-MM input PIO: synchroniser, optional debounce, edge capture (W1C), masked level IRQ.
// Define DEBOUNCE_EN to build the per-bit debounce counters; otherwise the filter is a plain register.
module niosii_pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  niosii_pio_in_edge_irq_if.slave bus,
  input  logic [WIDTH-1:0]       in_port_i,
  output logic                   irq_o
);

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_RSVD    = 2'd2,
    ADDR_EDGECAP = 2'd3
  } reg_addr_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  reg_addr_e        addr;
  logic             unused_ok;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // the synchroniser carries no reset since its contents are overwritten within two cycles.
  always_ff @(posedge clk) begin
    sync1_q <= in_port_i;
    sync2_q <= sync1_q;
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // A bit follows sync2 only after it has disagreed with filt for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign unused_ok = ^bus.writedata;
`else
  assign filt_d    = sync2_q;
  assign unused_ok = ^{bus.writedata, DEBOUNCE_CYCLES};
`endif

  always_comb begin
    ev = filt_q ^ prev_q;
    case (EDGE_TYPE)
      0:       ev = filt_q & ~prev_q;
      1:       ev = ~filt_q & prev_q;
      default: ev = filt_q ^ prev_q;
    endcase
  end

  assign addr  = reg_addr_e'(bus.address);
  assign wr_en = bus.chipselect & ~bus.write_n;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    clr       = '0;
    irqmask_d = irqmask_q;
    if (wr_en && addr == ADDR_EDGECAP) clr = bus.writedata[WIDTH-1:0];
    if (wr_en && addr == ADDR_IRQMASK) irqmask_d = bus.writedata[WIDTH-1:0];
    // A new edge in the same cycle as its clear keeps the bit set.
    cap_d = (cap_q & ~clr) | ev;
  end

  always_comb begin
    readdata_d = '0;
    case (addr)
      ADDR_DATA:    readdata_d = 32'(filt_q);
      ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
      ADDR_EDGECAP: readdata_d = 32'(cap_q);
      default:      readdata_d = '0;
    endcase
  end

  // Under reset filt and prev track the pins so levels already present raise no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= sync2_q;
      prev_q     <= sync2_q;
      cap_q      <= '0;
      irqmask_q  <= '0;
      readdata_q <= '0;
    end else begin
      filt_q     <= filt_d;
      prev_q     <= filt_q;
      cap_q      <= cap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq_o        = |(cap_q & irqmask_q);

endmodule

// File: tb/tb_niosii_pio_in_edge_irq.sv
// Directed bench for the input PIO: a rising-edge instance (a) and an any-edge instance (b)
// share pins and bus strobes; read expectations go through a small scoreboard queue.
module tb_niosii_pio_in_edge_irq;

`ifdef DEBOUNCE_EN
  localparam int DB = 15;
`else
  localparam int DB = 0;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          sel_b;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic        irq_a, irq_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  niosii_pio_in_edge_irq_if if_a ();
  niosii_pio_in_edge_irq_if if_b ();

  assign if_a.address    = address;
  assign if_a.chipselect = chipselect;
  assign if_a.write_n    = write_n;
  assign if_a.writedata  = writedata;
  assign if_b.address    = address;
  assign if_b.chipselect = chipselect;
  assign if_b.write_n    = write_n;
  assign if_b.writedata  = writedata;

  niosii_pio_in_edge_irq #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .bus       (if_a),
    .in_port_i (in_port),
    .irq_o     (irq_a)
  );

  niosii_pio_in_edge_irq #(.WIDTH(4), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(16)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .bus       (if_b),
    .in_port_i (in_port),
    .irq_o     (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read(input bit sel_b, input logic [1:0] a, input logic [31:0] exp, input string tag);
    exp_t e;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    e.tag   = tag;
    e.exp   = exp;
    e.sel_b = sel_b;
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    check(e.tag, e.sel_b ? if_b.readdata : if_a.readdata, e.exp);
    chipselect = 1'b0;
  endtask

  task automatic write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 4'hF;

    // Four-cycle reset with all pins high.
    ticks(2);
    read(1'b0, 2'd0, 32'h0, "rst_readdata");
    check("rst_irq", 32'(irq_a), 32'h0);
    tick();
    reset = 1'b0;
    read(1'b0, 2'd0, 32'hF, "rst_data");
    read(1'b0, 2'd3, 32'h0, "rst_cap_a");
    read(1'b1, 2'd3, 32'h0, "rst_cap_b");
    read(1'b0, 2'd1, 32'h0, "rst_mask");
    read(1'b0, 2'd2, 32'h0, "rsvd");
    check("rst_irq_after", 32'(irq_b), 32'h0);

    // Pins to 0, then 0 -> 5 with exact read latency on DATA.
    in_port = 4'h0;
    ticks(5 + DB);
    write(2'd3, 32'hF);
    read(1'b1, 2'd3, 32'h0, "clr_all_b");
    in_port = 4'h5;
    for (int i = 0; i < 3 + DB; i++) read(1'b0, 2'd0, 32'h0, "lat_old");
    read(1'b0, 2'd0, 32'h5, "lat_data");
    read(1'b0, 2'd3, 32'h5, "rise_cap");

    // Falling edges: ignored by the rising instance, captured by the any-edge one.
    write(2'd3, 32'hF);
    in_port = 4'h0;
    ticks(5 + DB);
    read(1'b0, 2'd3, 32'h0, "fall_ignored_a");
    read(1'b1, 2'd3, 32'h5, "fall_any_b");

    // Bit0 rise with IRQMASK=1, then W1C clears it.
    write(2'd3, 32'hF);
    write(2'd1, 32'h1);
    in_port = 4'h1;
    ticks(3 + DB);
    check("irq_pre", 32'(irq_a), 32'h0);
    tick();
    check("irq_rise", 32'(irq_a), 32'h1);
    read(1'b0, 2'd3, 32'h1, "cap_bit0");
    write(2'd3, 32'h1);
    check("irq_clr", 32'(irq_a), 32'h0);
    read(1'b0, 2'd3, 32'h0, "cap_clr");

    // Clear lands on the same edge as a new capture: set wins.
    in_port = 4'h0;
    ticks(5 + DB);
    write(2'd3, 32'hF);
    in_port = 4'h1;
    ticks(3 + DB);
    write(2'd3, 32'h1);
    read(1'b0, 2'd3, 32'h1, "set_wins");
    check("set_wins_irq", 32'(irq_a), 32'h1);

    // Dropping the mask deasserts irq but keeps the capture.
    write(2'd1, 32'h0);
    check("mask_clr_irq", 32'(irq_a), 32'h0);
    read(1'b0, 2'd3, 32'h1, "mask_clr_cap_kept");

    // Any-edge instance: bit3 toggled twice with mask 0, then unmask.
    write(2'd3, 32'hF);
    in_port = 4'h9;
    ticks(5 + DB);
    in_port = 4'h1;
    ticks(5 + DB);
    read(1'b1, 2'd3, 32'h8, "any_cap");
    read(1'b0, 2'd3, 32'h8, "rise_cap_bit3");
    check("any_irq_masked", 32'(irq_b), 32'h0);
    write(2'd1, 32'hFFFF_FFF8);
    check("any_irq_unmasked", 32'(irq_b), 32'h1);
    read(1'b1, 2'd1, 32'h8, "mask_readback");

    // Reset mid-operation drops pending captures and the mask.
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    read(1'b1, 2'd3, 32'h0, "rst_mid_cap");
    check("rst_mid_irq", 32'(irq_b), 32'h0);
    read(1'b1, 2'd1, 32'h0, "rst_mid_mask");
    read(1'b1, 2'd0, 32'h1, "rst_mid_data");

`ifdef DEBOUNCE_EN
    // 10-cycle glitch on bit2 is filtered; a long hold is accepted once.
    write(2'd3, 32'hF);
    in_port = 4'h5;
    ticks(10);
    in_port = 4'h1;
    ticks(25);
    read(1'b0, 2'd0, 32'h1, "glitch_data");
    read(1'b0, 2'd3, 32'h0, "glitch_cap");
    in_port = 4'h5;
    ticks(10);
    read(1'b0, 2'd0, 32'h1, "db_early");
    ticks(12);
    read(1'b0, 2'd0, 32'h5, "db_data");
    read(1'b0, 2'd3, 32'h4, "db_cap_once");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
